// File: rtl/has_sensor_conditioner.sv
// Input conditioning in front of the HAS2 controller. It synchronizes and debounces the door,
// window and fire contacts, and produces a moving average of the sampled temperature bus.
module has_sensor_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int SAMPLE_DIV = 8,
  parameter int AVG_LOG2   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sfd_raw,
  input  logic       srd_raw,
  input  logic       sw_raw,
  input  logic       sfa_raw,
  input  logic [6:0] st_raw,
  output logic       sfd,
  output logic       srd,
  output logic       sw,
  output logic       sfa,
  output logic [6:0] st,
  output logic       st_valid
);
  localparam int DEPTH   = 1 << AVG_LOG2;
  localparam int SUM_W   = 7 + AVG_LOG2;
  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PTR_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W  = AVG_LOG2 + 1;
  localparam int FAST_CH = 3;

  // Binary channels packed as {sfa, sw, srd, sfd}.
  logic [3:0] raw;
  logic [3:0] s1_q, s1_d, s2_q, s2_d, out_q, out_d;
  logic [3:0] cnt_q [4];
  logic [3:0] cnt_d [4];

  assign raw = {sfa_raw, sw_raw, srd_raw, sfd_raw};

  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    out_d = out_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = 4'd0;
      if (s2_q[i] != out_q[i]) begin
        if (i == FAST_CH && s2_q[i]) begin
          out_d[i] = 1'b1;
        end else if (cnt_q[i] + 4'd1 == 4'(DEB_CYCLES)) begin
          out_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // st_valid is a level, not a handshake: once high, st carries the window average and
  // changes only on accepted samples; it stays high until reset.
  logic [6:0]        st_s1_q, st_s1_d, st_s2_q, st_s2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [6:0]        win_q [DEPTH];
  logic [6:0]        win_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_new;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [6:0]        st_q, st_d;
  logic              valid_q, valid_d;
  logic              tick, accept;

  always_comb begin
    st_s1_d = st_raw;
    st_s2_d = st_s1_q;
    tick    = (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    // A sample is taken only when both sync stages agree, i.e. the bus is not mid-change.
    accept  = tick && (st_s1_q == st_s2_q);
    sum_new = sum_q - SUM_W'(win_q[ptr_q]) + SUM_W'(st_s2_q);
    for (int i = 0; i < DEPTH; i++) win_d[i] = win_q[i];
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    fill_d  = fill_q;
    st_d    = st_q;
    valid_d = valid_q;
    if (accept) begin
      win_d[ptr_q] = st_s2_q;
      ptr_d        = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      sum_d        = sum_new;
      if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
      if (fill_q >= FILL_W'(DEPTH - 1)) begin
        st_d    = 7'(sum_new >> AVG_LOG2);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      out_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      st_s1_q <= '0;
      st_s2_q <= '0;
      div_q   <= '0;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      st_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      out_q   <= out_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      st_s1_q <= st_s1_d;
      st_s2_q <= st_s2_d;
      div_q   <= div_d;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= win_d[i];
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      st_q    <= st_d;
      valid_q <= valid_d;
    end
  end

  assign sfd      = out_q[0];
  assign srd      = out_q[1];
  assign sw       = out_q[2];
  assign sfa      = out_q[3];
  assign st       = st_q;
  assign st_valid = valid_q;
endmodule

// File: tb/tb_has_sensor_conditioner.sv
// Bench for has_sensor_conditioner: directed scenarios plus randomized contacts and temperature,
// all outputs compared every cycle against a window-based reference model.
module tb_has_sensor_conditioner;
  localparam int DEB   = 4;
  localparam int SD    = 8;
  localparam int AL    = 2;
  localparam int DEPTH = 1 << AL;

  logic       clk = 1'b0;
  logic       rst;
  logic       sfd_raw, srd_raw, sw_raw, sfa_raw;
  logic [6:0] st_raw;
  logic       sfd, srd, sw, sfa;
  logic [6:0] st;
  logic       st_valid;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  has_sensor_conditioner #(.DEB_CYCLES(DEB), .SAMPLE_DIV(SD), .AVG_LOG2(AL)) dut (
    .clk(clk), .rst(rst),
    .sfd_raw(sfd_raw), .srd_raw(srd_raw), .sw_raw(sw_raw), .sfa_raw(sfa_raw),
    .st_raw(st_raw),
    .sfd(sfd), .srd(srd), .sw(sw), .sfa(sfa), .st(st), .st_valid(st_valid)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [11:0] dut_outs();
    return {sfa, sw, srd, sfd, st, st_valid};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_raw(input int ch, input logic v);
    case (ch)
      0: sfd_raw = v;
      1: srd_raw = v;
      2: sw_raw  = v;
      default: sfa_raw = v;
    endcase
  endtask

  function automatic logic get_raw(input int ch);
    case (ch)
      0: return sfd_raw;
      1: return srd_raw;
      2: return sw_raw;
      default: return sfa_raw;
    endcase
  endfunction

  function automatic logic get_out(input int ch);
    case (ch)
      0: return sfd;
      1: return srd;
      2: return sw;
      default: return sfa;
    endcase
  endfunction

  // Reference model: an output moves to level v once the last DEB synchronized samples all
  // equal v; the fire alarm rises as soon as a synchronized 1 appears. The temperature is the
  // mean of the last DEPTH accepted samples, taken every SD edges when the bus was stable.
  initial begin
    logic [3:0] hist[$];
    logic [6:0] st_hist[$];
    logic [6:0] acc[$];
    logic [3:0] m_out;
    logic [3:0] h;
    logic [6:0] m_st;
    logic       m_valid;
    logic       s2v, stable;
    int         n, sum;
    m_out = '0; m_st = '0; m_valid = 1'b0; n = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        hist = {};
        repeat (DEB + 1) hist.push_back(4'b0);
        st_hist = {};
        repeat (2) st_hist.push_back(7'd0);
        acc = {};
        n = 0; m_out = '0; m_st = '0; m_valid = 1'b0;
      end else begin
        n++;
        hist.push_back({sfa_raw, sw_raw, srd_raw, sfd_raw});
        while (hist.size() > DEB + 2) void'(hist.pop_front());
        st_hist.push_back(st_raw);
        while (st_hist.size() > 3) void'(st_hist.pop_front());
        for (int ch = 0; ch < 4; ch++) begin
          h = hist[DEB - 1];
          s2v = h[ch];
          stable = 1'b1;
          for (int i = 0; i < DEB; i++) begin
            h = hist[i];
            if (h[ch] != s2v) stable = 1'b0;
          end
          if (ch == 3 && s2v && !m_out[3]) m_out[3] = 1'b1;
          else if (stable && s2v != m_out[ch]) m_out[ch] = s2v;
        end
        if (n % SD == 0 && st_hist[1] == st_hist[0]) begin
          acc.push_back(st_hist[0]);
          while (acc.size() > DEPTH) void'(acc.pop_front());
          if (acc.size() == DEPTH) begin
            sum = 0;
            foreach (acc[i]) sum += int'(acc[i]);
            m_st = 7'(sum / DEPTH);
            m_valid = 1'b1;
          end
        end
      end
      exp_q.push_back({m_out, m_st, m_valid});
    end
  end

  // scoreboard monitor
  initial begin
    logic [11:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("sb_outputs", int'(dut_outs()), int'(exp));
      end
    end
  end

  // driver
  initial begin
    int hold[5];
    rst = 1'b1;
    {sfd_raw, srd_raw, sw_raw, sfa_raw} = 4'($urandom_range(0, 15));
    st_raw = 7'($urandom_range(0, 127));
    #1 rst = 1'b0;
    #2 check("reset_no_clock", int'(dut_outs()), 0);

    @(negedge clk);
    {sfd_raw, srd_raw, sw_raw, sfa_raw} = 4'b0;
    st_raw = 7'd20;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // averaging: 20,21,22,23 then 40 then all 127
    for (int e = 1; e <= 72; e++) begin
      st_raw = (e <= 32) ? 7'(20 + (e - 1) / 8) : ((e <= 40) ? 7'd40 : 7'd127);
      @(posedge clk); #1;
      if (e == 31) check("avg_not_full", int'({st, st_valid}), 0);
      if (e == 32) check("avg_first", int'({st, st_valid}), (21 << 1) | 1);
      if (e == 40) check("avg_fifth", int'({st, st_valid}), (26 << 1) | 1);
      if (e == 72) check("avg_all_127", int'({st, st_valid}), (127 << 1) | 1);
      @(negedge clk);
    end

    // clean steps on sfd, srd, sw
    for (int ch = 0; ch < 3; ch++) begin
      set_raw(ch, 1'b1);
      repeat (5) @(posedge clk);
      #1 check($sformatf("step%0d_k4", ch), int'(get_out(ch)), 0);
      @(posedge clk);
      #1 check($sformatf("step%0d_k5", ch), int'(get_out(ch)), 1);
      @(negedge clk);
      set_raw(ch, 1'b0);
      repeat (8) @(negedge clk);
    end

    // glitch rejection on srd
    srd_raw = 1'b1;
    repeat (3) @(negedge clk);
    srd_raw = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_3", int'(srd), 0);
    srd_raw = 1'b1; repeat (3) @(negedge clk);
    srd_raw = 1'b0; @(negedge clk);
    srd_raw = 1'b1; repeat (3) @(negedge clk);
    srd_raw = 1'b0; repeat (8) @(negedge clk);
    check("glitch_3_1_3", int'(srd), 0);

    // fire alarm: fast assert, glitch-tolerant, debounced release
    sfa_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("sfa_k1", int'(sfa), 0);
    @(posedge clk);
    #1 check("sfa_k2", int'(sfa), 1);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      sfa_raw = 1'b0; repeat (2) @(negedge clk);
      sfa_raw = 1'b1; repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("sfa_glitch_hold", int'(sfa), 1);
    sfa_raw = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("sfa_m4", int'(sfa), 1);
    @(posedge clk);
    #1 check("sfa_m5", int'(sfa), 0);
    @(negedge clk);

    // async reset mid-debounce with a full window
    sfd_raw = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_mid_run", int'(dut_outs()), 0);
    @(negedge clk);
    sfd_raw = 1'b0;
    st_raw = 7'd50;
    rst = 1'b1;

    // refill after reset, with the first tick skipped by a bus change
    for (int e = 1; e <= 40; e++) begin
      st_raw = (e <= 6) ? 7'd50 : 7'd51;
      @(posedge clk); #1;
      if (e == 32) check("skip_not_full", int'({st, st_valid}), 0);
      if (e == 40) check("skip_refilled", int'({st, st_valid}), (51 << 1) | 1);
      @(negedge clk);
    end

    // randomized phase
    for (int i = 0; i < 5; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) rst = 1'b0;
      if (cyc == 1502) rst = 1'b1;
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          set_raw(ch, ~get_raw(ch));
          hold[ch] = $urandom_range(1, 7);
        end else begin
          hold[ch]--;
        end
      end
      if (hold[4] == 0) begin
        st_raw = 7'($urandom_range(0, 127));
        hold[4] = $urandom_range(1, 20);
      end else begin
        hold[4]--;
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/has_sensor_conditioner.md
# has_sensor_conditioner

Input-conditioning stage placed directly upstream of the HAS2 home-automation controller. It synchronizes the raw door, window and fire-alarm contacts and debounces them, and it smooths the 7-bit temperature bus. Its outputs drive HAS2's sfd/srd/sw/sfa/st inputs with clean, glitch-free levels. Fire-alarm assertion bypasses the debounce delay so that alarm response is not slowed.

## Interface
- DEB_CYCLES, 4: consecutive stable cycles required to change a debounced output; legal range 1–15.
- SAMPLE_DIV, 8: temperature sample period in clocks; legal range 2–256.
- AVG_LOG2, 2: log2 of the moving-average window depth; depth = 4 by default.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; all state cleared while low.
- sfd_raw, srd_raw, sw_raw, sfa_raw  in  1 each  raw contacts, asynchronous to clk.
- st_raw  in  7  raw temperature, unsigned, quasi-static, asynchronous.
- sfd, srd, sw  out  1 each  debounced contacts to HAS2.
- sfa  out  1  fire alarm: fast assert, debounced deassert.
- st  out  7  averaged temperature to HAS2.
- st_valid  out  1  high once the averaging window has filled.

## Operation
- **Reset values.** While rst=0, every output is 0, including st_valid. All synchronizers, counters, the window and the sum are also 0.
- **Synchronization.**
  - Each binary input passes through two flops, s1 then s2.
  - st_raw passes through the same two 7-bit stages.
- **Debounce (sfd, srd, sw, and sfa deassert).**
  - Each channel has a per-channel counter cnt of 4 bits.
  - If s2 equals out, cnt is set to 0.
  - Otherwise cnt increments.
  - When cnt would reach DEB_CYCLES, out is set to s2 and cnt is cleared, both on that same edge.
  - Any return of s2 to out before that point clears cnt, so partial counts never accumulate.
- **sfa fast assert.** If s2=1 and sfa=0, sfa is set to 1 on the next edge with no count. Deassertion uses the debounce rule above.
- **Temperature sampling.**
  - A free-running divider counts 0 to SAMPLE_DIV−1, starting at 0 after reset.
  - A tick occurs on the edge where the divider equals SAMPLE_DIV−1.
  - On a tick, a sample is accepted only if the st s1 and s2 stages are equal, i.e. the bus is stable. Otherwise the tick is skipped: the window, sum and fill count are all unchanged.
- **Moving average.**
  - The window is a circular buffer of 2^AVG_LOG2 entries, each 7 bits wide.
  - On each accepted sample, the oldest entry is replaced and sum ← sum − oldest + new.
  - sum is 7+AVG_LOG2 bits wide (9 bits by default) and never overflows.
  - fill counts accepted samples and saturates at the window depth.
- **Output.**
  - On an accepted sample that brings fill to, or keeps fill at, full depth, st ← sum_new >> AVG_LOG2 (truncated) and st_valid ← 1.
  - Before the window is full, st=0 and st_valid=0.
  - After the window is full, st changes only on accepted samples. st_valid stays 1 until reset.
- **Simultaneous events.** All channels are independent. A debounce event and a temperature tick on the same edge both take effect.

## Timing
- Let edge k be the first edge at which s1 captures a new level on a binary input.
- **Debounced change:** the output changes at edge k+1+DEB_CYCLES (k+5 by default), provided the input is held.
- **sfa rise:** sfa changes at edge k+2.
- **Temperature, constant stable input after reset release:**
  - The first tick is at edge SAMPLE_DIV.
  - st and st_valid first update at edge 2^AVG_LOG2·SAMPLE_DIV (edge 32 by default).
- **st after an accepted sample:** st updates on the tick edge itself. The new value is visible in the following cycle.
- **Reset mid-operation:** asynchronous clear with no clock required.
  - After release, the debounce counters restart.
  - The window must refill completely before st_valid rises again.

## Test plan
- **Reset check:** assert rst=0 with arbitrary inputs → all outputs 0 and st_valid=0, with no clock edge. Release rst, with all raw inputs 0 → outputs stay 0.
- **Clean step:** sfd_raw goes 0→1 before edge k, DEB_CYCLES=4 → sfd=0 through edge k+4 and sfd=1 at edge k+5. Repeat for srd and sw.
- **Glitch rejection:**
  - A 3-cycle high pulse on srd_raw → srd remains 0.
  - A 3-high/1-low/3-high pattern → srd remains 0, because the counter clears.
- **Fire-alarm path:**
  - sfa_raw goes 1 before edge k → sfa=1 at edge k+2.
  - Then 2-cycle low glitches → sfa stays 1.
  - A stable low from edge m → sfa=0 at edge m+5.
- **Averaging:**
  - st_raw = 20, 21, 22, 23, each held across one sample period → st=21 (86>>2) and st_valid=1 at edge 32.
  - All samples 127 → st=127 with no overflow.
  - A 5th sample of 40 → st=26 (106>>2).
  - st_raw changed on the cycle before a tick → that sample is skipped and fill/sum are unchanged.
- **Async reset mid-run:** pull rst low mid-debounce, with the window full → outputs 0 immediately. After release, st_valid=0 until 4 new accepted samples.
